// File: rtl/hazard_unit_pip_if.sv
// Signal bundle between the 5-stage pipeline datapath and its hazard unit.
// The datapath (master) supplies register tags and memory status; the hazard
// unit (slave) returns forwarding selects, register enables, flushes and
// observability counters.
//
// Data-memory handshake: dmem_req is held high by the MEM stage for as long as
// an access is outstanding; the access completes in the cycle where
// dmem_req && dmem_ready are both high. Any cycle with dmem_req && !dmem_ready
// is a wait cycle that freezes the whole pipeline.
interface hazard_unit_pip_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic             mem_mem_read;
  logic [4:0]       wb_rd;
  logic             wb_reg_write;
  logic             redirect;
  logic             dmem_req;
  logic             dmem_ready;

  logic [1:0]       forward_rs1;
  logic [1:0]       forward_rs2;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic [1:0]       hazard_state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_reg_write, ex_mem_read,
    output mem_rd, mem_reg_write, mem_mem_read,
    output wb_rd, wb_reg_write,
    output redirect, dmem_req, dmem_ready,
    input  forward_rs1, forward_rs2,
    input  pc_write, if_id_write, if_id_flush,
    input  id_ex_write, id_ex_flush, ex_mem_write,
    input  hazard_state, stall_cycles, flush_count, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_reg_write, ex_mem_read,
    input  mem_rd, mem_reg_write, mem_mem_read,
    input  wb_rd, wb_reg_write,
    input  redirect, dmem_req, dmem_ready,
    output forward_rs1, forward_rs2,
    output pc_write, if_id_write, if_id_flush,
    output id_ex_write, id_ex_flush, ex_mem_write,
    output hazard_state, stall_cycles, flush_count, mem_timeout
  );
endinterface

// File: rtl/hazard_unit_pip.sv
// Hazard controller for the 5-stage RV32I pipeline: operand forwarding,
// load-use stalls, memory-wait freezes and branch/jump redirect flushes,
// plus a memory-wait watchdog and saturating stall/flush counters.
module hazard_unit_pip #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 256
) (
  input logic              clk,
  input logic              rst,   // asynchronous, active low
  hazard_unit_pip_if.slave bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  // Action taken in a cycle; the registered copy is exported as hazard_state.
  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_MEM_WAIT   = 2'b10,
    ST_REDIRECT   = 2'b11
  } action_t;

  action_t           action;
  action_t           state_q;
  logic              pending_redirect;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_timeout_q;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  flush_q;

  logic [1:0] fwd1_c;
  logic [1:0] fwd2_c;
  logic       load_use;
  logic       mem_wait;
  logic       pc_write_c;
  logic       if_id_write_c;
  logic       if_id_flush_c;
  logic       id_ex_write_c;
  logic       id_ex_flush_c;
  logic       ex_mem_write_c;
  logic [1:0] fwd1_o;
  logic [1:0] fwd2_o;

  // Youngest producer wins; loads in EX/MEM have no data yet, so they are
  // skipped here and caught by the load-use stall instead.
  function automatic logic [1:0] fwd_sel(
    input logic       uses,
    input logic [4:0] rs,
    input logic [4:0] ex_rd,
    input logic       ex_wr,
    input logic       ex_ld,
    input logic [4:0] mem_rd,
    input logic       mem_wr,
    input logic       mem_ld,
    input logic [4:0] wb_rd,
    input logic       wb_wr
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && rs != 5'd0) begin
      if (ex_wr && ex_rd == rs && !ex_ld)          sel = 2'b11;
      else if (mem_wr && mem_rd == rs && !mem_ld)  sel = 2'b10;
      else if (wb_wr && wb_rd == rs)               sel = 2'b01;
    end
    return sel;
  endfunction

  // A used, nonzero source that depends on a load still in EX or MEM.
  function automatic logic load_dep(
    input logic       uses,
    input logic [4:0] rs,
    input logic [4:0] ex_rd,
    input logic       ex_wr,
    input logic       ex_ld,
    input logic [4:0] mem_rd,
    input logic       mem_wr,
    input logic       mem_ld
  );
    return uses && rs != 5'd0 &&
           ((ex_wr && ex_ld && ex_rd == rs) ||
            (mem_wr && mem_ld && mem_rd == rs));
  endfunction

  // Forward selects and hazard detection for both ID sources.
  always_comb begin
    fwd1_c = fwd_sel(bus.id_uses_rs1, bus.id_rs1,
                     bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read,
                     bus.mem_rd, bus.mem_reg_write, bus.mem_mem_read,
                     bus.wb_rd, bus.wb_reg_write);
    fwd2_c = fwd_sel(bus.id_uses_rs2, bus.id_rs2,
                     bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read,
                     bus.mem_rd, bus.mem_reg_write, bus.mem_mem_read,
                     bus.wb_rd, bus.wb_reg_write);
    load_use = load_dep(bus.id_uses_rs1, bus.id_rs1,
                        bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read,
                        bus.mem_rd, bus.mem_reg_write, bus.mem_mem_read) ||
               load_dep(bus.id_uses_rs2, bus.id_rs2,
                        bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read,
                        bus.mem_rd, bus.mem_reg_write, bus.mem_mem_read);
    mem_wait = bus.dmem_req && !bus.dmem_ready;
  end

  // Pick this cycle's action by priority: wait, redirect, load stall, run.
  always_comb begin
    action = ST_RUN;
    if (mem_wait)                               action = ST_MEM_WAIT;
    else if (bus.redirect || pending_redirect)  action = ST_REDIRECT;
    else if (load_use)                          action = ST_LOAD_STALL;
  end

  // Decode the action into enables/flushes; reset forces a frozen, flushed pipe.
  always_comb begin
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_write_c  = 1'b1;
    id_ex_flush_c  = 1'b0;
    ex_mem_write_c = 1'b1;
    fwd1_o         = fwd1_c;
    fwd2_o         = fwd2_c;
    case (action)
      ST_MEM_WAIT: begin
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        id_ex_write_c  = 1'b0;
        ex_mem_write_c = 1'b0;
      end
      ST_REDIRECT: begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
      end
      ST_LOAD_STALL: begin
        // Hold PC and IF/ID, push a bubble into EX, let older stages drain.
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        id_ex_flush_c = 1'b1;
      end
      default: ;
    endcase
    if (!rst) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_write_c  = 1'b0;
      ex_mem_write_c = 1'b0;
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
      fwd1_o         = 2'b00;
      fwd2_o         = 2'b00;
    end
  end

  // Action register, redirect latch, watchdog and saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_RUN;
      pending_redirect <= 1'b0;
      wait_cnt         <= '0;
      mem_timeout_q    <= 1'b0;
      stall_q          <= '0;
      flush_q          <= '0;
    end else begin
      state_q <= action;

      if (!pc_write_c && stall_q != '1)
        stall_q <= stall_q + 1'b1;

      if (action == ST_REDIRECT && flush_q != '1)
        flush_q <= flush_q + 1'b1;

      // A redirect seen while frozen is remembered and replayed on release.
      if (action == ST_MEM_WAIT) begin
        if (bus.redirect)
          pending_redirect <= 1'b1;
      end else if (action == ST_REDIRECT) begin
        pending_redirect <= 1'b0;
      end

      if (action == ST_MEM_WAIT) begin
        if (wait_cnt == WAIT_LAST)
          mem_timeout_q <= 1'b1;
        else
          wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign bus.forward_rs1  = fwd1_o;
  assign bus.forward_rs2  = fwd2_o;
  assign bus.pc_write     = pc_write_c;
  assign bus.if_id_write  = if_id_write_c;
  assign bus.if_id_flush  = if_id_flush_c;
  assign bus.id_ex_write  = id_ex_write_c;
  assign bus.id_ex_flush  = id_ex_flush_c;
  assign bus.ex_mem_write = ex_mem_write_c;
  assign bus.hazard_state = state_q;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
  assign bus.mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_unit_pip.sv
// Directed bench for hazard_unit_pip: forwarding priority, load-use stall,
// memory wait with deferred redirect, watchdog, reset and counter saturation.
module tb_hazard_unit_pip;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  hazard_unit_pip_if #(.CNT_W(CNT_W)) bus ();

  hazard_unit_pip #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected enables in order: pc, if_id_w, id_ex_w, ex_mem_w, if_id_f, id_ex_f
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, bus.pc_write, bus.if_id_write, bus.id_ex_write,
              bus.ex_mem_write, bus.if_id_flush, bus.id_ex_flush}, {26'd0, exp});
  endtask

  task automatic chk_regs(input string tag, input logic [1:0] st,
                          input int stalls, input int flushes, input logic tmo);
    chk({tag, "_state"}, {30'd0, bus.hazard_state}, {30'd0, st});
    chk({tag, "_stalls"}, {28'd0, bus.stall_cycles}, 32'(stalls));
    chk({tag, "_flushes"}, {28'd0, bus.flush_count}, 32'(flushes));
    chk({tag, "_tmo"}, {31'd0, bus.mem_timeout}, {31'd0, tmo});
  endtask

  // Driver tasks
  task automatic clear_inputs();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0;
    bus.mem_rd = 5'd0; bus.mem_reg_write = 1'b0; bus.mem_mem_read = 1'b0;
    bus.wb_rd = 5'd0; bus.wb_reg_write = 1'b0;
    bus.redirect = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] CTL_RUN   = 6'b111100;
  localparam logic [5:0] CTL_LOAD  = 6'b001101;
  localparam logic [5:0] CTL_WAIT  = 6'b000000;
  localparam logic [5:0] CTL_REDIR = 6'b111111;
  localparam logic [5:0] CTL_RESET = 6'b000011;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    clear_inputs();
    // Forwarding candidate present while in reset: outputs must stay forced.
    bus.ex_rd = 5'd5; bus.ex_reg_write = 1'b1;
    bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
    #2;
    chk_ctl("reset_ctl", CTL_RESET);
    chk("reset_fwd1", {30'd0, bus.forward_rs1}, 32'd0);
    chk_regs("reset", 2'b00, 0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b1;

    // EX forward, no load
    #1;
    chk("ex_fwd1", {30'd0, bus.forward_rs1}, 32'd3);
    chk("ex_fwd2_unused", {30'd0, bus.forward_rs2}, 32'd0);
    chk_ctl("ex_fwd_ctl", CTL_RUN);
    tick();
    chk_regs("ex_fwd", 2'b00, 0, 0, 1'b0);

    // EX beats WB for rs1, MEM for rs2
    bus.id_rs2 = 5'd6; bus.id_uses_rs2 = 1'b1;
    bus.mem_rd = 5'd6; bus.mem_reg_write = 1'b1;
    bus.wb_rd = 5'd5; bus.wb_reg_write = 1'b1;
    #1;
    chk("prio_fwd1", {30'd0, bus.forward_rs1}, 32'd3);
    chk("prio_fwd2", {30'd0, bus.forward_rs2}, 32'd2);
    tick();

    // MEM beats WB when EX does not write
    clear_inputs();
    bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
    bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
    bus.mem_rd = 5'd5; bus.mem_reg_write = 1'b1;
    bus.wb_rd = 5'd5; bus.wb_reg_write = 1'b1;
    bus.ex_rd = 5'd5;
    #1;
    chk("mem_fwd1", {30'd0, bus.forward_rs1}, 32'd2);
    chk("mem_fwd2", {30'd0, bus.forward_rs2}, 32'd2);
    tick();

    // WB only
    clear_inputs();
    bus.id_rs1 = 5'd7; bus.id_uses_rs1 = 1'b1;
    bus.id_rs2 = 5'd7;
    bus.wb_rd = 5'd7; bus.wb_reg_write = 1'b1;
    #1;
    chk("wb_fwd1", {30'd0, bus.forward_rs1}, 32'd1);
    chk("wb_fwd2_unused", {30'd0, bus.forward_rs2}, 32'd0);
    tick();

    // x0 never forwards or stalls, even behind a load to x0
    clear_inputs();
    bus.ex_rd = 5'd0; bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
    bus.id_uses_rs1 = 1'b1;
    #1;
    chk("x0_fwd1", {30'd0, bus.forward_rs1}, 32'd0);
    chk_ctl("x0_ctl", CTL_RUN);
    tick();
    chk_regs("x0", 2'b00, 0, 0, 1'b0);

    // Load-use: two bubbles, then WB forward
    clear_inputs();
    bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b1;
    bus.ex_rd = 5'd7; bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
    #1;
    chk_ctl("lu1_ctl", CTL_LOAD);
    chk("lu1_fwd2", {30'd0, bus.forward_rs2}, 32'd0);
    tick();
    chk_regs("lu1", 2'b01, 1, 0, 1'b0);
    bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rd = 5'd0;
    bus.mem_rd = 5'd7; bus.mem_reg_write = 1'b1; bus.mem_mem_read = 1'b1;
    #1;
    chk_ctl("lu2_ctl", CTL_LOAD);
    chk("lu2_fwd2", {30'd0, bus.forward_rs2}, 32'd0);
    tick();
    chk_regs("lu2", 2'b01, 2, 0, 1'b0);
    bus.mem_reg_write = 1'b0; bus.mem_mem_read = 1'b0; bus.mem_rd = 5'd0;
    bus.wb_rd = 5'd7; bus.wb_reg_write = 1'b1;
    #1;
    chk_ctl("lu3_ctl", CTL_RUN);
    chk("lu3_fwd2", {30'd0, bus.forward_rs2}, 32'd1);
    tick();
    chk_regs("lu3", 2'b00, 2, 0, 1'b0);

    // Reset asserted in the middle of a load stall
    clear_inputs();
    bus.id_rs1 = 5'd9; bus.id_uses_rs1 = 1'b1;
    bus.ex_rd = 5'd9; bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
    bus.redirect = 1'b0;
    tick();
    chk_regs("mid_pre", 2'b01, 3, 0, 1'b0);
    rst = 1'b0;
    #1;
    chk_ctl("mid_rst_ctl", CTL_RESET);
    chk_regs("mid_rst", 2'b00, 0, 0, 1'b0);
    tick();
    rst = 1'b1;
    clear_inputs();
    #1;
    chk_ctl("post_rst_ctl", CTL_RUN);
    tick();
    chk_regs("post_rst", 2'b00, 0, 0, 1'b0);

    // Memory wait with redirect in wait cycle 2, applied on release
    bus.dmem_req = 1'b1;
    #1;
    chk_ctl("w1_ctl", CTL_WAIT);
    tick();
    chk_regs("w1", 2'b10, 1, 0, 1'b0);
    bus.redirect = 1'b1;
    #1;
    chk_ctl("w2_ctl", CTL_WAIT);
    tick();
    chk_regs("w2", 2'b10, 2, 0, 1'b0);
    bus.redirect = 1'b0;
    #1;
    chk_ctl("w3_ctl", CTL_WAIT);
    tick();
    chk_regs("w3", 2'b10, 3, 0, 1'b0);
    bus.dmem_ready = 1'b1;
    #1;
    chk_ctl("w4_ctl", CTL_REDIR);
    tick();
    chk_regs("w4", 2'b11, 3, 1, 1'b0);
    clear_inputs();
    #1;
    chk_ctl("w5_ctl", CTL_RUN);
    tick();
    chk_regs("w5", 2'b00, 3, 1, 1'b0);

    // Redirect coinciding with dmem_ready is applied at once
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b1; bus.redirect = 1'b1;
    #1;
    chk_ctl("rd_ready_ctl", CTL_REDIR);
    tick();
    chk_regs("rd_ready", 2'b11, 3, 2, 1'b0);

    // Redirect overrides a simultaneous load-use
    clear_inputs();
    bus.redirect = 1'b1;
    bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b1;
    bus.ex_rd = 5'd7; bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
    #1;
    chk_ctl("rd_lu_ctl", CTL_REDIR);
    tick();
    chk_regs("rd_lu", 2'b11, 3, 3, 1'b0);

    // Watchdog: rises after the 4th consecutive wait cycle
    clear_inputs();
    bus.dmem_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("wd_tmo_%0d", i), {31'd0, bus.mem_timeout}, {31'd0, (i >= 4)});
    end
    chk("wd_stalls", {28'd0, bus.stall_cycles}, 32'd8);
    bus.dmem_ready = 1'b1;
    #1;
    chk_ctl("wd_rel_ctl", CTL_RUN);
    tick();
    chk_regs("wd_rel", 2'b00, 8, 3, 1'b1);

    // Saturation of both counters
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk_regs("sat_stall", 2'b10, 15, 3, 1'b1);
    clear_inputs();
    bus.redirect = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk_regs("sat_flush", 2'b11, 15, 15, 1'b1);

    // Sticky flag clears only on reset
    clear_inputs();
    rst = 1'b0;
    #1;
    chk_regs("final_rst", 2'b00, 0, 0, 1'b0);
    tick();
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net in case the directed sequence never completes.
  initial begin
    #100000;
    $display("FAIL timeout: sequence did not complete");
    $fatal(1, "bench timeout");
  end

endmodule
